multicycle_main_control: RTL

//  Main control FSM for the multi-cycle MIPS datapath. It decodes i_opcode from the IR and sequences the datapath.
//  It drives o_aluOp to the ALU-control decoder: 00=add (ld/st/addi/PC+4), 01=sub (beq), 10=R-type (decoded from funct).
//  It stalls on a memory ready handshake and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_decode.sv | 91 +++++++++
 rtl/multicycle_main_control.sv | 102 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU-control
// codes, mux selects and the main FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control-word decode. Handshake-dependent strobes are
// returned as enables so the parent can gate them with memReady / zero.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_on_ready,
    output logic       ir_write_on_ready,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op
);

    always_comb begin
        pc_write          = 1'b0;
        pc_write_cond     = 1'b0;
        pc_write_on_ready = 1'b0;
        ir_write_on_ready = 1'b0;
        pc_source         = PC_SRC_ALU;
        iord              = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_to_reg        = 1'b0;
        reg_dst           = 1'b0;
        reg_write         = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = SRC_B_REG;
        alu_op            = ALU_OP_ADD;

        case (state)
            S_FETCH: begin
                mem_read          = 1'b1;
                alu_src_b         = SRC_B_FOUR;
                ir_write_on_ready = 1'b1;
                pc_write_on_ready = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here, before the opcode is known
                alu_src_b = SRC_B_IMM_SH2;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_RTYPE;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register, next-state
// sequencing with memory-ready stalls, and the retired-instruction counter.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_memReady,
    output logic             o_pcEn,
    output logic [1:0]       o_pcSource,
    output logic             o_iorD,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_irWrite,
    output logic             o_memToReg,
    output logic             o_regDst,
    output logic             o_regWrite,
    output logic             o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic [1:0]       o_aluOp,
    output logic             o_illegal,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    state_t state;
    logic   retire;
    logic   pc_write;
    logic   pc_write_cond;
    logic   pc_write_on_ready;
    logic   ir_write_on_ready;

    multicycle_ctrl_decode u_decode (
        .state             (state),
        .pc_write          (pc_write),
        .pc_write_cond     (pc_write_cond),
        .pc_write_on_ready (pc_write_on_ready),
        .ir_write_on_ready (ir_write_on_ready),
        .pc_source         (o_pcSource),
        .iord              (o_iorD),
        .mem_read          (o_memRead),
        .mem_write         (o_memWrite),
        .mem_to_reg        (o_memToReg),
        .reg_dst           (o_regDst),
        .reg_write         (o_regWrite),
        .alu_src_a         (o_aluSrcA),
        .alu_src_b         (o_aluSrcB),
        .alu_op            (o_aluOp)
    );

    assign o_pcEn    = pc_write | (pc_write_on_ready & i_memReady) | (pc_write_cond & i_zero);
    assign o_irWrite = ir_write_on_ready & i_memReady;
    assign o_illegal = (state == S_DECODE) && !is_legal_opcode(i_opcode);
    assign o_state   = state;

    // An instruction retires on the edge that leaves its last state for FETCH
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
            S_MEMWR:                                      retire = i_memReady;
            default:                                      retire = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_INIT;
            o_retired <= '0;
        end else begin
            if (retire) begin
                o_retired <= o_retired + CNT_W'(1);
            end
            case (state)
                S_INIT:  state <= S_FETCH;
                S_FETCH: if (i_memReady) state <= S_DECODE;
                S_DECODE: begin
                    case (i_opcode)
                        OP_RTYPE:     state <= S_EXEC;
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDIEX;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (i_memReady) state <= S_MEMWB;
                S_MEMWR:  if (i_memReady) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ADDIEX: state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

endmodule
